// File: rtl/traffic_phase_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// traffic_phase_ctrl
//
// N-phase signalised-junction controller. Each phase gets right-of-way in
// round-robin order and runs through green, yellow and all-red. A phase can
// hand over early (gap-out) once it has served its minimum green and its own
// approach is empty. The controller also provides:
//   - a pedestrian walk lamp at the start of a phase's green
//   - peak-hour doubling of phase 0 green
//   - police/emergency preemption that holds one phase green
//   - night-time all-yellow flashing
//
// Ports
//   clk          system clock
//   Reset        asynchronous, active-high reset
//   Tick         1-cycle timing pulse, one per timing unit
//   Night        night mode request (all-yellow flashing)
//   Peak         peak mode, phase 0 green doubled (sampled at green entry)
//   Police       preemption request (level)
//   PolicePhase  phase to hold green under preemption (>= PHASES means 0)
//   CarReq       per-phase vehicle presence (level)
//   PedReq       per-phase pedestrian button (pulse or level)
//   Red/Yellow/Green  per-phase lamp drives (registered)
//   Walk         per-phase pedestrian walk lamp (registered)
//   RestTime     ticks remaining in the current interval
//   ActivePhase  phase currently owning right-of-way
//   State        FSM state code: 0 ALLRED, 1 GREEN, 2 YELLOW, 3 PREEMPT, 4 FLASH
// ---------------------------------------------------------------------------
module traffic_phase_ctrl #(
  parameter int PHASES    = 2,
  parameter int TW        = 7,
  parameter int GREEN_T   = 30,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int MIN_GREEN = 5,
  parameter int WALK_T    = 8
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Tick,
  input  logic              Night,
  input  logic              Peak,
  input  logic              Police,
  input  logic [1:0]        PolicePhase,
  input  logic [PHASES-1:0] CarReq,
  input  logic [PHASES-1:0] PedReq,
  output logic [PHASES-1:0] Red,
  output logic [PHASES-1:0] Yellow,
  output logic [PHASES-1:0] Green,
  output logic [PHASES-1:0] Walk,
  output logic [TW-1:0]     RestTime,
  output logic [1:0]        ActivePhase,
  output logic [2:0]        State
);

  typedef enum logic [2:0] {
    ST_ALLRED  = 3'd0,
    ST_GREEN   = 3'd1,
    ST_YELLOW  = 3'd2,
    ST_PREEMPT = 3'd3,
    ST_FLASH   = 3'd4
  } state_t;

  // Peak green is twice the nominal green, clipped to what RestTime can hold.
  localparam int PEAK_RAW = 2 * GREEN_T;
  localparam int TW_MAX   = (1 << TW) - 1;
  localparam int PEAK_T   = (PEAK_RAW > TW_MAX) ? TW_MAX : PEAK_RAW;

  localparam logic [TW-1:0]     GREEN_LD  = TW'(GREEN_T);
  localparam logic [TW-1:0]     PEAK_LD   = TW'(PEAK_T);
  localparam logic [TW-1:0]     YELLOW_LD = TW'(YELLOW_T);
  localparam logic [TW-1:0]     ALLRED_LD = TW'(ALLRED_T);
  localparam logic [TW-1:0]     MIN_LD    = TW'(MIN_GREEN);
  localparam logic [TW-1:0]     WALK_LD   = TW'(WALK_T);
  localparam logic [TW-1:0]     ONE       = TW'(1);
  localparam logic [PHASES-1:0] BIT0      = PHASES'(1);

  state_t            state_q, state_n;
  logic [1:0]        active_q, active_n;
  logic [TW-1:0]     rest_q, rest_n;
  logic [TW-1:0]     served_q, served_n, served_inc;
  logic [TW-1:0]     walk_q, walk_n;
  logic [PHASES-1:0] ped_q, ped_n;
  logic              flash_q, flash_n;

  logic [PHASES-1:0] demand, dsh, car_sh, ped_sh, clear_mask, active_oh;
  logic [1:0]        next_phase, police_sel;
  logic              found, car_active, next_ped, rest_last, gap_out;

  logic [PHASES-1:0] red_n, yellow_n, green_n, walk_lamp_n;

  // Green duration for a phase entering green; Peak only lengthens phase 0.
  function automatic logic [TW-1:0] green_load(input logic [1:0] ph, input logic pk);
    return (pk && ph == 2'd0) ? PEAK_LD : GREEN_LD;
  endfunction

  // Demand bookkeeping: which phase should be served next, whether the
  // current approach still has cars, and which phase preemption targets.
  // The search starts just after the active phase so every demanding phase
  // is reached within one round; with no other demand the active phase
  // is chosen again, which is what makes rest-in-green work.
  always_comb begin
    demand     = CarReq | ped_q;
    next_phase = active_q;
    found      = 1'b0;
    dsh        = '0;
    for (int k = 1; k < PHASES; k++) begin
      dsh = demand >> ((int'(active_q) + k) % PHASES);
      if (!found && dsh[0]) begin
        found      = 1'b1;
        next_phase = 2'((int'(active_q) + k) % PHASES);
      end
    end
    car_sh     = CarReq >> active_q;
    car_active = car_sh[0];
    ped_sh     = ped_q >> next_phase;
    next_ped   = ped_sh[0];
    police_sel = ({1'b0, PolicePhase} < 3'(PHASES)) ? PolicePhase : 2'd0;
  end

  // Next-state logic for the phase sequencer. Intervals count down on
  // Tick and expire on the Tick that finds RestTime at 1. Police requests
  // are honoured from green immediately, but a yellow or all-red interval
  // already in progress is allowed to finish first so clearance is never
  // cut short. Night only takes effect at the end of an all-red, so the
  // junction is always cleared before flashing starts.
  always_comb begin
    state_n    = state_q;
    active_n   = active_q;
    rest_n     = rest_q;
    served_n   = served_q;
    walk_n     = walk_q;
    flash_n    = flash_q;
    clear_mask = '0;
    served_inc = (served_q < MIN_LD) ? served_q + ONE : served_q;
    rest_last  = (rest_q == ONE);
    gap_out    = (served_inc >= MIN_LD) && !car_active && (next_phase != active_q);

    case (state_q)
      ST_ALLRED: begin
        if (Tick) begin
          if (rest_last) begin
            if (Police) begin
              state_n  = ST_PREEMPT;
              active_n = police_sel;
              rest_n   = '0;
            end else if (Night) begin
              state_n = ST_FLASH;
              rest_n  = '0;
              flash_n = 1'b1;
            end else begin
              state_n    = ST_GREEN;
              active_n   = next_phase;
              rest_n     = green_load(next_phase, Peak);
              served_n   = '0;
              walk_n     = next_ped ? WALK_LD : '0;
              clear_mask = BIT0 << next_phase;
            end
          end else begin
            rest_n = rest_q - ONE;
          end
        end
      end

      ST_GREEN: begin
        if (Police) begin
          walk_n = '0;
          if (active_q == police_sel) begin
            state_n = ST_PREEMPT;
            rest_n  = '0;
          end else begin
            state_n = ST_YELLOW;
            rest_n  = YELLOW_LD;
          end
        end else if (Tick) begin
          served_n = served_inc;
          walk_n   = (walk_q != '0) ? walk_q - ONE : walk_q;
          // Gap-out and expiry landing on the same Tick collapse into one
          // move to yellow.
          if (gap_out || (rest_last && next_phase != active_q)) begin
            state_n = ST_YELLOW;
            rest_n  = YELLOW_LD;
            walk_n  = '0;
          end else if (rest_last) begin
            rest_n = green_load(active_q, Peak);
          end else begin
            rest_n = rest_q - ONE;
          end
        end
      end

      ST_YELLOW: begin
        if (Tick) begin
          if (rest_last) begin
            state_n = ST_ALLRED;
            rest_n  = ALLRED_LD;
          end else begin
            rest_n = rest_q - ONE;
          end
        end
      end

      ST_PREEMPT: begin
        walk_n = '0;
        rest_n = '0;
        if (!Police) begin
          // Leave via all-red; round-robin resumes after the held phase.
          state_n = ST_ALLRED;
          rest_n  = ALLRED_LD;
        end else begin
          active_n = police_sel;
        end
      end

      ST_FLASH: begin
        // Police outranks Night: drop out through all-red, whose expiry
        // then enters preemption.
        if (Police || !Night) begin
          state_n = ST_ALLRED;
          rest_n  = ALLRED_LD;
          flash_n = 1'b0;
        end else if (Tick) begin
          flash_n = ~flash_q;
        end
      end

      default: begin
        state_n = ST_ALLRED;
        rest_n  = ALLRED_LD;
      end
    endcase

    // A new press wins over the clear on the same cycle, so a button
    // pushed exactly at green entry is still remembered for next time.
    ped_n = (ped_q & ~clear_mask) | PedReq;
  end

  // Lamp pattern for the state being entered, so the lamp registers change
  // on the same edge as State and never show a stale combination.
  always_comb begin
    active_oh   = BIT0 << active_n;
    red_n       = '1;
    yellow_n    = '0;
    green_n     = '0;
    walk_lamp_n = '0;
    case (state_n)
      ST_GREEN: begin
        red_n       = ~active_oh;
        green_n     = active_oh;
        walk_lamp_n = (walk_n != '0) ? active_oh : '0;
      end
      ST_PREEMPT: begin
        red_n   = ~active_oh;
        green_n = active_oh;
      end
      ST_YELLOW: begin
        red_n    = ~active_oh;
        yellow_n = active_oh;
      end
      ST_FLASH: begin
        red_n    = '0;
        yellow_n = {PHASES{flash_n}};
      end
      default: begin
        red_n = '1;
      end
    endcase
  end

  // All controller state and every lamp output live in this one register
  // bank; reset parks the junction in all-red with phase 0 about to be
  // reconsidered on the first Tick.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_ALLRED;
      active_q <= 2'd0;
      rest_q   <= ALLRED_LD;
      served_q <= '0;
      walk_q   <= '0;
      ped_q    <= '0;
      flash_q  <= 1'b0;
      Red      <= '1;
      Yellow   <= '0;
      Green    <= '0;
      Walk     <= '0;
    end else begin
      state_q  <= state_n;
      active_q <= active_n;
      rest_q   <= rest_n;
      served_q <= served_n;
      walk_q   <= walk_n;
      ped_q    <= ped_n;
      flash_q  <= flash_n;
      Red      <= red_n;
      Yellow   <= yellow_n;
      Green    <= green_n;
      Walk     <= walk_lamp_n;
    end
  end

  assign State       = state_q;
  assign ActivePhase = active_q;
  assign RestTime    = rest_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_traffic_phase_ctrl
//
// Directed bench for traffic_phase_ctrl with PHASES=2. Each step drives a
// Tick or an input change, queues the expected output word, and compares
// it once the DUT has had time to update.
// ---------------------------------------------------------------------------
module tb_traffic_phase_ctrl;

  logic       clk;
  logic       Reset;
  logic       Tick;
  logic       Night;
  logic       Peak;
  logic       Police;
  logic [1:0] PolicePhase;
  logic [1:0] CarReq;
  logic [1:0] PedReq;
  logic [1:0] Red;
  logic [1:0] Yellow;
  logic [1:0] Green;
  logic [1:0] Walk;
  logic [6:0] RestTime;
  logic [1:0] ActivePhase;
  logic [2:0] State;

  traffic_phase_ctrl #(
    .PHASES(2), .TW(7), .GREEN_T(30), .YELLOW_T(3),
    .ALLRED_T(1), .MIN_GREEN(5), .WALK_T(8)
  ) dut (
    .clk(clk),
    .Reset(Reset),
    .Tick(Tick),
    .Night(Night),
    .Peak(Peak),
    .Police(Police),
    .PolicePhase(PolicePhase),
    .CarReq(CarReq),
    .PedReq(PedReq),
    .Red(Red),
    .Yellow(Yellow),
    .Green(Green),
    .Walk(Walk),
    .RestTime(RestTime),
    .ActivePhase(ActivePhase),
    .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [19:0] FULL_MASK  = 20'hFFFFF;
  localparam logic [19:0] FLASH_MASK = 20'hF80FF;

  typedef struct {
    string       tag;
    logic [19:0] exp;
    logic [19:0] mask;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [1:0] oh(int a);
    return 2'(1 << a);
  endfunction

  task automatic pushExp(string tag, logic [2:0] st, int act, int rest,
                         logic [1:0] r, logic [1:0] y, logic [1:0] g,
                         logic [1:0] w, logic [19:0] mask);
    exp_t e;
    e.tag  = tag;
    e.exp  = {st, 2'(act), 7'(rest), r, y, g, w};
    e.mask = mask;
    sb.push_back(e);
  endtask

  task automatic expG(string tag, int a, int rest, bit walk);
    pushExp(tag, 3'd1, a, rest, ~oh(a), 2'b00, oh(a), walk ? oh(a) : 2'b00, FULL_MASK);
  endtask

  task automatic expY(string tag, int a, int rest);
    pushExp(tag, 3'd2, a, rest, ~oh(a), oh(a), 2'b00, 2'b00, FULL_MASK);
  endtask

  task automatic expAR(string tag, int a, int rest);
    pushExp(tag, 3'd0, a, rest, 2'b11, 2'b00, 2'b00, 2'b00, FULL_MASK);
  endtask

  task automatic expPre(string tag, int a);
    pushExp(tag, 3'd3, a, 0, ~oh(a), 2'b00, oh(a), 2'b00, FULL_MASK);
  endtask

  task automatic expFlash(string tag, int a, logic [1:0] y);
    pushExp(tag, 3'd4, a, 0, 2'b00, y, 2'b00, 2'b00, FLASH_MASK);
  endtask

  // One timing unit: a single-cycle Tick followed by idle cycles.
  task automatic applyStimulus();
    @(negedge clk) Tick = 1'b1;
    @(negedge clk) Tick = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [19:0] obs;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("[TB] FAIL scoreboard_empty obs=none exp=entry");
    end else begin
      e   = sb.pop_front();
      obs = {State, ActivePhase, RestTime, Red, Yellow, Green, Walk};
      assert ((obs & e.mask) === (e.exp & e.mask)) else begin
        errors++;
        $error("[TB] FAIL %s observed=%h expected=%h (st,act,rest,R,Y,G,W)",
               e.tag, obs & e.mask, e.exp & e.mask);
      end
    end
  endtask

  task automatic stepG(string tag, int a, int rest, bit walk);
    expG(tag, a, rest, walk);
    applyStimulus();
    checkOutput();
  endtask

  task automatic stepY(string tag, int a, int rest);
    expY(tag, a, rest);
    applyStimulus();
    checkOutput();
  endtask

  task automatic stepAR(string tag, int a, int rest);
    expAR(tag, a, rest);
    applyStimulus();
    checkOutput();
  endtask

  task automatic stepPre(string tag, int a);
    expPre(tag, a);
    applyStimulus();
    checkOutput();
  endtask

  task automatic stepFlash(string tag, int a, logic [1:0] y);
    expFlash(tag, a, y);
    applyStimulus();
    checkOutput();
  endtask

  // n ticks of green counting down from load; walk lit while k < walkLen.
  task automatic greenRun(int a, int load, int n, int walkLen);
    for (int k = 1; k <= n; k++)
      stepG($sformatf("green%0d_rest%0d", a, load - k), a, load - k, k < walkLen);
  endtask

  // Ending tick of a green, the yellow and all-red, then the next green.
  task automatic cycleOut(int a, int nxt, int load, bit walk);
    stepY($sformatf("yellow%0d_r3", a), a, 3);
    stepY($sformatf("yellow%0d_r2", a), a, 2);
    stepY($sformatf("yellow%0d_r1", a), a, 1);
    stepAR($sformatf("allred_after%0d", a), a, 1);
    stepG($sformatf("green%0d_entry", nxt), nxt, load, walk);
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Reset = 1'b1; Tick = 1'b0; Night = 1'b0; Peak = 1'b0; Police = 1'b0;
    PolicePhase = 2'd0; CarReq = 2'b00; PedReq = 2'b00;
    repeat (3) @(negedge clk);
    expAR("reset_state", 0, 1);
    Reset = 1'b0;
    settle();
    checkOutput();

    // No demand: first all-red expiry keeps phase 0.
    stepG("first_green0", 0, 30, 1'b0);

    // Both approaches busy: full greens alternate.
    CarReq = 2'b11;
    greenRun(0, 30, 29, 0);
    cycleOut(0, 1, 30, 1'b0);
    greenRun(1, 30, 29, 0);
    cycleOut(1, 0, 30, 1'b0);

    // Phase 0 empty, phase 1 waiting: gap-out on the 5th tick.
    CarReq = 2'b10;
    greenRun(0, 30, 4, 0);
    cycleOut(0, 1, 30, 1'b0);

    // Peak doubles phase 0 only; pedestrian press during G0 served in G1.
    CarReq = 2'b11;
    Peak   = 1'b1;
    greenRun(1, 30, 29, 0);
    cycleOut(1, 0, 60, 1'b0);
    PedReq = 2'b10;
    @(negedge clk) PedReq = 2'b00;
    greenRun(0, 60, 59, 0);
    cycleOut(0, 1, 30, 1'b1);
    Peak = 1'b0;
    greenRun(1, 30, 29, 8);
    cycleOut(1, 0, 30, 1'b0);
    greenRun(0, 30, 29, 0);
    cycleOut(0, 1, 30, 1'b0);
    greenRun(1, 30, 29, 0);
    cycleOut(1, 0, 30, 1'b0);

    // Police for phase 1 while phase 0 is green.
    PolicePhase = 2'd1;
    Police      = 1'b1;
    expY("police_yellow0", 0, 3);
    settle();
    checkOutput();
    stepY("police_yellow0_r2", 0, 2);
    stepY("police_yellow0_r1", 0, 1);
    stepAR("police_allred", 0, 1);
    stepPre("preempt1", 1);
    stepPre("preempt1_hold", 1);
    Police = 1'b0;
    expAR("police_release", 1, 1);
    settle();
    checkOutput();
    stepG("resume_green0", 0, 30, 1'b0);

    // Out-of-range PolicePhase maps to phase 0, already green.
    PolicePhase = 2'd3;
    Police      = 1'b1;
    expPre("preempt_oob_phase0", 0);
    settle();
    checkOutput();
    Police = 1'b0;
    expAR("oob_release", 0, 1);
    settle();
    checkOutput();
    stepG("after_oob_green1", 1, 30, 1'b0);

    // Night: flashing after the next all-red, back to service on release.
    Night = 1'b1;
    greenRun(1, 30, 29, 0);
    stepY("night_yellow1_r3", 1, 3);
    stepY("night_yellow1_r2", 1, 2);
    stepY("night_yellow1_r1", 1, 1);
    stepAR("night_allred", 1, 1);
    stepFlash("flash_on", 1, 2'b11);
    stepFlash("flash_off", 1, 2'b00);
    stepFlash("flash_on_again", 1, 2'b11);
    Night = 1'b0;
    expAR("night_release", 1, 1);
    settle();
    checkOutput();
    stepG("day_green0", 0, 30, 1'b0);

    // Asynchronous reset in the middle of a green.
    greenRun(0, 30, 3, 0);
    @(negedge clk);
    #2 Reset = 1'b1;
    expAR("reset_mid_green", 0, 1);
    #1 checkOutput();
    @(negedge clk) Reset = 1'b0;
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
